// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with busy scoreboard for the integer register file
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*5-1:0]      req_rd,
    input  logic [NREQ*XLEN-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   sb_set,
    input  logic [4:0]             sb_rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [4:0]             rd_q,
    output logic                   hazard_rs1,
    output logic                   hazard_rs2,
    output logic                   hazard_rd,
    output logic                   rf_we,
    output logic [4:0]             rf_rd,
    output logic [XLEN-1:0]        rf_wdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant_idx;
    logic [PW:0]     pos;
    logic [NREQ-1:0] grant;
    logic            found;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     busy;
    logic [31:0]     busy_next;

    // Walk the requesters starting at ptr; the first valid one wins.
    // Grants are masked while reset is held so nothing handshakes then.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        pos       = '0;
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                pos = {1'b0, ptr} + (PW+1)'(k);
                if (pos >= (PW+1)'(NREQ))
                    pos = pos - (PW+1)'(NREQ);
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req_valid[i] && (pos[PW-1:0] == PW'(i))) begin
                        found       = 1'b1;
                        grant[i]    = 1'b1;
                        grant_idx   = PW'(i);
                        sel_rd      = req_rd[5*i +: 5];
                        sel_data    = req_data[XLEN*i +: XLEN];
                    end
                end
            end
        end
    end

    assign req_ready = grant;

    // Set beats clear on the same index; x0 can never become busy.
    always_comb begin
        busy_next = busy;
        if (rf_we)
            busy_next[rf_rd] = 1'b0;
        if (sb_set && (sb_rd != 5'd0))
            busy_next[sb_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            busy     <= '0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            busy  <= busy_next;
            rf_we <= found && (sel_rd != 5'd0);
            if (found) begin
                ptr      <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    assign hazard_rs1 = busy[rs1];
    assign hazard_rs2 = busy[rs2];
    assign hazard_rd  = busy[rd_q];

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry integer register file of the RV32IM core. It shares the register file's single write port among NREQ write-back sources with a registered round-robin grant. The sources are the ALU, the load unit and the multi-cycle MUL/DIV unit. It also keeps a per-register busy scoreboard so the issue stage can stall on RAW and WAW hazards against long-latency results. It sits between the execute/memory units and the register file's write port (`rd`, `write_data`, `reg_write`).

## Interface
Parameters:
- XLEN, 32, data width
- NREQ, 3, number of write-back requesters (index 0 = ALU, 1 = load, 2 = MUL/DIV)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i holds a result
- req_rd  in  NREQ*5  destination of requester i (bits 5i+4:5i)
- req_data  in  NREQ*XLEN  result of requester i
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- sb_set  in  1  issue stage dispatches a long-latency op
- sb_rd  in  5  destination of that op
- rs1, rs2, rd_q  in  5 each  hazard query addresses
- hazard_rs1, hazard_rs2, hazard_rd  out  1 each  scoreboard busy bit for the queried address (combinational)
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  5  register file write address (registered)
- rf_wdata  out  XLEN  register file write data (registered)

## Operation
- Arbitration is round-robin with a rotation pointer `ptr`, range 0..NREQ-1.
  - Search order is ptr, ptr+1, … mod NREQ. The first requester with req_valid high is granted.
  - req_ready is combinational from req_valid and ptr. At most one bit is high per cycle, and it is never high for a requester whose req_valid is low.
  - After a grant to requester i, ptr becomes (i+1) mod NREQ. With no grant, ptr holds.
- Requester rule: once req_valid is high, req_rd and req_data must stay stable until the grant. The arbiter may rely on this.
- Write port:
  - On a grant, rf_we/rf_rd/rf_wdata load the granted rd/data on the next edge.
  - With no grant, rf_we is 0 the next cycle. rf_rd and rf_wdata hold their previous values.
- x0 handling:
  - A granted request with rd = 0 completes its handshake, but rf_we stays 0.
  - sb_set with sb_rd = 0 is ignored.
- Scoreboard (32 bits, busy[0] always 0):
  - Set: sb_set with sb_rd ≠ 0 sets busy[sb_rd] at the edge.
  - Clear: at the edge ending a cycle with rf_we = 1, busy[rf_rd] clears. This is the same edge at which the register file captures the data.
  - Set and clear on the same index in the same cycle: set wins.
  - sb_set to an already-busy register is an issue-stage error; the bit stays 1.
  - The issue stage must stall on hazard_rd, so at most one long-latency op per register is in flight.
- Hazard outputs: hazard_x = busy[x]. They are combinational and carry no bypass.

## Timing
- Reset (asynchronous assert, synchronous release): ptr = 0, busy = 0, rf_we = 0, rf_rd = 0, rf_wdata = 0.
  - req_ready and hazard_* follow combinationally: all 0 while no requester is valid.
- Reset asserted mid-operation:
  - Any pending rf_we is dropped and the scoreboard is cleared.
  - Requesters must re-present their results after release.
- Latency: grant in cycle N, rf_we high in cycle N+1, register file write at the end of N+1.
  - A read of that register in cycle N+2 returns the new value.
  - The busy bit is low from N+2 on.
- Throughput: one write per cycle sustained. A requester held valid is granted within NREQ cycles.
- Granting and setting never stall; the arbiter has no backpressure into the register file.

## Test plan
- Reset: hold rst_n = 0 with all requesters valid. Expect req_ready = 0, rf_we = 0 and busy all 0. Release, and the first grant goes to req 0 (ptr = 0).
- Single ALU write: req_valid = 001, rd = 5, data = 0xDEADBEEF. Expect req_ready = 001 the same cycle, then next cycle rf_we = 1, rf_rd = 5, rf_wdata = 0xDEADBEEF. After that, rf_we = 0.
- Round-robin: all three requesters valid continuously (rd 1/2/3). Expect grants 001, 010, 100, 001, … and one rf_we per cycle for 6 cycles. No requester is granted twice before the others.
- Scoreboard: sb_set with sb_rd = 7, then hazard_rs1 = 1 for rs1 = 7. MUL/DIV is granted with rd = 7 in cycle N. Expect hazard_rs1 = 1 through N+1 and 0 in N+2.
- Same-cycle set/clear: rf_we = 1 with rf_rd = 9 while sb_set with sb_rd = 9. Expect busy[9] = 1 after the edge.
- x0: sb_set with sb_rd = 0 leaves hazard_rs1 = 0 for rs1 = 0. A request with rd = 0 is granted (req_ready pulses) and rf_we stays 0.
